// File: rtl/ram_sum_seq.sv
// ram_sum_seq: owns the single port of a 1024x10 RAM (async read, sync write).
// On start it fetches a base pointer from RAM[PTR_ADDR], reads signed operands
// at base and base+1, writes their sum to base+2 and pulses done.
// Optional feature: define SUM_SAT_EN to saturate the sum on signed overflow
// instead of wrapping; the overflow flag behaves the same in both builds.
module ram_sum_seq #(
   parameter int DW       = 10,
   parameter int AW       = 10,
   parameter int PTR_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          overflow,
   output logic [DW-1:0] result,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PTR,
      S_OPA,
      S_OPB,
      S_WR,
      S_DONE
   } state_t;

   state_t        state_q,     state_d;
   logic [AW-1:0] base_q,      base_d;
   logic [DW-1:0] a_q,         a_d;
   logic          ovf_pend_q,  ovf_pend_d;
   logic          overflow_q,  overflow_d;
   logic [DW-1:0] result_q,    result_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic          mem_we_q,    mem_we_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          busy_q,      busy_d;
   logic          done_q,      done_d;

   logic [DW-1:0] raw;
   logic          ovf;
   logic [DW-1:0] sum;

   // Sum of operand a and operand b; b is presented on mem_rdata while in OPB,
   // so the write data is ready to register on the OPB->WR edge.
   always_comb begin
      raw = a_q + mem_rdata;
      ovf = (a_q[DW-1] == mem_rdata[DW-1]) && (raw[DW-1] != a_q[DW-1]);
`ifdef SUM_SAT_EN
      if (ovf) begin
         sum = a_q[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
         sum = raw;
      end
`else
      sum = raw;
`endif
   end

   // Next-state and next-output computation; outputs are computed for the
   // state being entered so that every port comes straight from a flop.
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      base_d      = base_q;
      a_d         = a_q;
      ovf_pend_d  = ovf_pend_q;
      overflow_d  = overflow_q;
      result_d    = result_q;
      mem_addr_d  = '0;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_PTR;
               overflow_d = 1'b0;
               mem_addr_d = AW'(PTR_ADDR);
            end
         end
         S_PTR: begin
            state_d    = S_OPA;
            base_d     = AW'(mem_rdata);
            mem_addr_d = AW'(mem_rdata);
         end
         S_OPA: begin
            state_d    = S_OPB;
            a_d        = mem_rdata;
            mem_addr_d = base_q + AW'(1);
         end
         S_OPB: begin
            // Operand b is consumed directly from mem_rdata, so it needs no
            // register of its own.
            state_d     = S_WR;
            mem_addr_d  = base_q + AW'(2);
            mem_we_d    = 1'b1;
            mem_wdata_d = sum;
            ovf_pend_d  = ovf;
         end
         S_WR: begin
            state_d    = S_DONE;
            result_d   = mem_wdata_q;
            overflow_d = ovf_pend_q;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset clears everything, including mem_we,
   // so no write can occur once rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         a_q         <= '0;
         ovf_pend_q  <= 1'b0;
         overflow_q  <= 1'b0;
         result_q    <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge values computed above, independent of statement order.
         state_q     <= state_d;
         base_q      <= base_d;
         a_q         <= a_d;
         ovf_pend_q  <= ovf_pend_d;
         overflow_q  <= overflow_d;
         result_q    <= result_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign result    = result_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_sum_seq.sv
// Directed bench for ram_sum_seq with a behavioural 1024x10 RAM.
module tb_ram_sum_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       busy;
   logic       done;
   logic       overflow;
   logic [9:0] result;
   logic [9:0] mem_addr;
   logic       mem_we;
   logic [9:0] mem_wdata;
   logic [9:0] mem_rdata;

   logic [9:0] ram [1024];

   int tests_run;
   int fail_count;
   int write_count;
   int done_count;
   logic [9:0] last_waddr;

`ifdef SUM_SAT_EN
   localparam logic [9:0] EXP_POS_OVF = 10'h1FF;
   localparam logic [9:0] EXP_NEG_OVF = 10'h200;
`else
   localparam logic [9:0] EXP_POS_OVF = 10'h200;
   localparam logic [9:0] EXP_NEG_OVF = 10'h1FF;
`endif

   ram_sum_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .result    (result),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: asynchronous read, synchronous write
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
   end

   // Monitors: count writes and done pulses seen at clock edges
   always @(posedge clk) begin
      if (mem_we) begin
         write_count <= write_count + 1;
         last_waddr  <= mem_addr;
      end
      if (done) done_count <= done_count + 1;
   end

   // Pulse start for one edge, then sample busy/done after each of six edges.
   // Called and returns on a negedge.
   task automatic run_op(output logic [5:0] busy_pat, output logic [5:0] done_pat);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         busy_pat[i] = busy;
         done_pat[i] = done;
         if (i < 5) @(negedge clk);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      wait_cycles(2);
      tests_run++;
      if ({busy, done, overflow, mem_we} !== 4'b0000) begin
         fail_count++;
         $display("FAIL reset_flags: got %b expected 0000", {busy, done, overflow, mem_we});
      end
      tests_run++;
      if ({result, mem_addr, mem_wdata} !== 30'd0) begin
         fail_count++;
         $display("FAIL reset_data: got %h expected 0", {result, mem_addr, mem_wdata});
      end
      rst_n = 1'b1;
      wait_cycles(1);
   endtask

   task automatic test_basic;
      logic [5:0] bp, dp;
      int w0;
      ram[0] = 10'd10; ram[10] = 10'd5; ram[11] = 10'h3FD; ram[12] = 10'h155;
      w0 = write_count;
      run_op(bp, dp);
      tests_run++;
      if (ram[12] !== 10'h002) begin
         fail_count++; $display("FAIL basic_ram: got %h expected 002", ram[12]);
      end
      tests_run++;
      if (result !== 10'h002 || overflow !== 1'b0) begin
         fail_count++; $display("FAIL basic_result: got %h/%b expected 002/0", result, overflow);
      end
      tests_run++;
      if (bp !== 6'b011111) begin
         fail_count++; $display("FAIL basic_busy: got %b expected 011111", bp);
      end
      tests_run++;
      if (dp !== 6'b010000) begin
         fail_count++; $display("FAIL basic_done: got %b expected 010000", dp);
      end
      tests_run++;
      if (write_count - w0 !== 1 || last_waddr !== 10'd12) begin
         fail_count++; $display("FAIL basic_writes: got %0d@%0d expected 1@12", write_count - w0, last_waddr);
      end
   endtask

   task automatic test_overflow;
      logic [5:0] bp, dp;
      ram[0] = 10'd10; ram[10] = 10'h1FF; ram[11] = 10'h001;
      run_op(bp, dp);
      tests_run++;
      if (ram[12] !== EXP_POS_OVF || result !== EXP_POS_OVF || overflow !== 1'b1) begin
         fail_count++;
         $display("FAIL ovf_pos: got %h/%h/%b expected %h/%h/1", ram[12], result, overflow, EXP_POS_OVF, EXP_POS_OVF);
      end
      ram[10] = 10'h200; ram[11] = 10'h3FF;
      run_op(bp, dp);
      tests_run++;
      if (ram[12] !== EXP_NEG_OVF || result !== EXP_NEG_OVF || overflow !== 1'b1) begin
         fail_count++;
         $display("FAIL ovf_neg: got %h/%h/%b expected %h/%h/1", ram[12], result, overflow, EXP_NEG_OVF, EXP_NEG_OVF);
      end
   endtask

   task automatic test_wrap;
      logic [5:0] bp, dp;
      int w0, d0;
      ram[0] = 10'd1022; ram[1022] = 10'd7; ram[1023] = 10'd8;
      w0 = write_count; d0 = done_count;
      run_op(bp, dp);
      tests_run++;
      if (ram[0] !== 10'd15 || write_count - w0 !== 1 || last_waddr !== 10'd0 || done_count - d0 !== 1) begin
         fail_count++;
         $display("FAIL wrap_1022: got ram0=%0d writes=%0d addr=%0d dones=%0d expected 15/1/0/1",
                  ram[0], write_count - w0, last_waddr, done_count - d0);
      end
      // base=1023: operands at 1023 (3) and 0 (the pointer itself, 0x3FF = -1)
      ram[0] = 10'd1023; ram[1023] = 10'd3; ram[1] = 10'h155;
      run_op(bp, dp);
      tests_run++;
      if (ram[1] !== 10'd2 || last_waddr !== 10'd1 || ram[0] !== 10'd1023) begin
         fail_count++;
         $display("FAIL wrap_1023: got ram1=%0d addr=%0d ram0=%0d expected 2/1/1023", ram[1], last_waddr, ram[0]);
      end
   endtask

   task automatic test_ignored_start;
      int w0, d0;
      ram[0] = 10'd10; ram[10] = 10'd1; ram[11] = 10'd2; ram[12] = 10'd0;
      w0 = write_count; d0 = done_count;
      start = 1'b1; @(negedge clk);   // accepted; now in PTR
      start = 1'b0; @(negedge clk);   // now in OPA
      start = 1'b1; @(negedge clk);   // seen during OPA; now in OPB
      start = 1'b0; @(negedge clk);   // now in WR
      start = 1'b1; @(negedge clk);   // seen during WR; now in DONE
      start = 1'b0;
      wait_cycles(10);
      tests_run++;
      if (write_count - w0 !== 1 || done_count - d0 !== 1 || ram[12] !== 10'd3) begin
         fail_count++;
         $display("FAIL ignored_start: got writes=%0d dones=%0d ram12=%0d expected 1/1/3",
                  write_count - w0, done_count - d0, ram[12]);
      end
   endtask

   task automatic test_back_to_back;
      int w0, d0;
      w0 = write_count; d0 = done_count;
      start = 1'b1;
      wait_cycles(18);
      start = 1'b0;
      wait_cycles(8);
      tests_run++;
      if (done_count - d0 !== 3 || write_count - w0 !== 3) begin
         fail_count++;
         $display("FAIL back_to_back: got dones=%0d writes=%0d expected 3/3", done_count - d0, write_count - w0);
      end
   endtask

   task automatic test_reset_mid;
      logic [5:0] bp, dp;
      int w0;
      ram[0] = 10'd10; ram[10] = 10'd4; ram[11] = 10'd4; ram[12] = 10'h155;
      w0 = write_count;
      // Drop reset mid-cycle while in OPB (two edges after the accepting edge)
      start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, overflow, mem_we, result, mem_addr, mem_wdata} !== 34'd0) begin
         fail_count++;
         $display("FAIL rst_opb: got %h expected 0", {busy, done, overflow, mem_we, result, mem_addr, mem_wdata});
      end
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
      // Drop reset mid-cycle while in WR, with mem_we asserted
      start = 1'b1; @(negedge clk); start = 1'b0; wait_cycles(3);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (mem_we !== 1'b0 || {busy, done, overflow, result, mem_addr, mem_wdata} !== 33'd0) begin
         fail_count++;
         $display("FAIL rst_wr: got we=%b rest=%h expected 0/0", mem_we,
                  {busy, done, overflow, result, mem_addr, mem_wdata});
      end
      @(negedge clk);
      tests_run++;
      if (ram[12] !== 10'h155 || write_count - w0 !== 0) begin
         fail_count++;
         $display("FAIL rst_no_write: got ram12=%h writes=%0d expected 155/0", ram[12], write_count - w0);
      end
      rst_n = 1'b1; @(negedge clk);
      run_op(bp, dp);
      tests_run++;
      if (ram[12] !== 10'd8 || result !== 10'd8 || dp !== 6'b010000) begin
         fail_count++;
         $display("FAIL rst_recover: got ram12=%0d result=%0d done=%b expected 8/8/010000", ram[12], result, dp);
      end
   endtask

   task automatic test_two_ops;
      logic [5:0] bp, dp;
      ram[0] = 10'd10; ram[10] = 10'h1FF; ram[11] = 10'h001;
      run_op(bp, dp);
      tests_run++;
      if (overflow !== 1'b1) begin
         fail_count++; $display("FAIL two_first_ovf: got %b expected 1", overflow);
      end
      ram[0] = 10'd20; ram[20] = 10'h010; ram[21] = 10'h020; ram[22] = 10'd0;
      start = 1'b1; @(negedge clk); start = 1'b0;
      tests_run++;
      if (overflow !== 1'b0 || result !== EXP_POS_OVF) begin
         fail_count++;
         $display("FAIL two_ovf_clear: got %b/%h expected 0/%h", overflow, result, EXP_POS_OVF);
      end
      wait_cycles(5);
      tests_run++;
      if (ram[22] !== 10'h030 || result !== 10'h030 || overflow !== 1'b0 || ram[12] !== EXP_POS_OVF) begin
         fail_count++;
         $display("FAIL two_second: got ram22=%h result=%h ovf=%b ram12=%h expected 030/030/0/%h",
                  ram[22], result, overflow, ram[12], EXP_POS_OVF);
      end
   endtask

   initial begin
      tests_run   = 0;
      fail_count  = 0;
      write_count = 0;
      done_count  = 0;
      last_waddr  = '0;
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      rst_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      test_reset;
      test_basic;
      test_overflow;
      test_wrap;
      test_ignored_start;
      test_back_to_back;
      test_reset_mid;
      test_two_ops;
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
